dac_ramp_ctrl: RTL and testbench

DAC_RAMP_CTRL -- requirements
Module: dac_ramp_ctrl

---
 rtl/dac_ramp_ctrl.sv | 143 ++++++++++++++
 tb/tb_dac_ramp_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_ramp_ctrl.sv
// DAC code ramp controller: steps a registered 8-bit code toward a target with a
// programmable dwell between steps, plus manual up/down adjust while idle.
module dac_ramp_ctrl #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               CLK_i,
  input  logic               RST_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               zero_i,
  input  logic [7:0]         target_i,
  input  logic [7:0]         step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               man_evt_i,
  input  logic               man_dir_i,
  output logic [7:0]         dac_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_STEP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [7:0]         r_cur;
  logic [7:0]         r_tgt;
  logic [7:0]         r_stp;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwl;
  logic               r_done;
  logic               r_rst_q;

  state_t             w_state_nxt;
  logic [7:0]         w_cur_nxt;
  logic [7:0]         w_tgt_nxt;
  logic [7:0]         w_stp_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [DWELL_W-1:0] w_dwl_nxt;
  logic               w_done_nxt;
  logic [8:0]         w_sum;
  logic [8:0]         w_dif;
  logic [7:0]         w_step_val;

  // Keeps the datapath in reset for the first edge after RST_i is released.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) r_rst_q <= 1'b1;
    else       r_rst_q <= 1'b0;
  end

  // 9-bit arithmetic so a step past either rail clamps to the target instead of wrapping.
  always_comb begin
    w_sum = {1'b0, r_cur} + {1'b0, r_stp};
    w_dif = {1'b0, r_cur} - {1'b0, r_stp};
    if (r_cur < r_tgt) begin
      w_step_val = (w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[7:0];
    end else begin
      w_step_val = (w_dif[8] || (w_dif[7:0] <= r_tgt)) ? r_tgt : w_dif[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_tgt_nxt   = r_tgt;
    w_stp_nxt   = r_stp;
    w_cnt_nxt   = r_cnt;
    w_dwl_nxt   = r_dwl;
    w_done_nxt  = 1'b0;
    if (zero_i) begin
      w_cur_nxt   = '0;
      w_state_nxt = S_IDLE;
    end else if (stop_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_tgt_nxt = target_i;
            w_cnt_nxt = dwell_i;
            w_dwl_nxt = dwell_i;
            w_stp_nxt = (step_i == '0) ? 8'd1 : step_i;
            if (target_i == r_cur) w_done_nxt  = 1'b1;
            else                   w_state_nxt = S_DWELL;
          end else if (man_evt_i) begin
            if (man_dir_i && (r_cur != 8'hFF))     w_cur_nxt = r_cur + 8'd1;
            else if (!man_dir_i && (r_cur != '0))  w_cur_nxt = r_cur - 8'd1;
          end
        end
        S_DWELL: begin
          if (r_cnt == '0) w_state_nxt = S_STEP;
          else             w_cnt_nxt   = r_cnt - DWELL_W'(1);
        end
        S_STEP: begin
          w_cur_nxt = w_step_val;
          if (w_step_val == r_tgt) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DWELL;
            w_cnt_nxt   = r_dwl;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_tgt   <= '0;
      r_stp   <= 8'd1;
      r_cnt   <= '0;
      r_dwl   <= '0;
      r_done  <= 1'b0;
    end else if (r_rst_q) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_tgt   <= '0;
      r_stp   <= 8'd1;
      r_cnt   <= '0;
      r_dwl   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_tgt   <= w_tgt_nxt;
      r_stp   <= w_stp_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwl   <= w_dwl_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign dac_o  = r_cur;
  assign busy_o = (r_state != S_IDLE);
  assign done_o = r_done;

endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// Bench for dac_ramp_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a countdown-based behavioural model.
module tb_dac_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, zero = 1'b0;
  logic [7:0]  target = '0, step = '0;
  logic [15:0] dwell = '0;
  logic        man_evt = 1'b0, man_dir = 1'b0;
  logic [7:0]  dac;
  logic        busy, done;

  int n_chk = 0;
  int n_err = 0;

  dac_ramp_ctrl #(.DWELL_W(16)) dut (
    .CLK_i(clk), .RST_i(rst), .start_i(start), .stop_i(stop), .zero_i(zero),
    .target_i(target), .step_i(step), .dwell_i(dwell),
    .man_evt_i(man_evt), .man_dir_i(man_dir),
    .dac_o(dac), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_k counts edges remaining before the next code move.
  int m_cur = 0, m_tgt = 0, m_stp = 1, m_dwl = 0, m_k = 0;
  bit m_ramp = 0, m_done = 0, m_hold = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = 0; m_ramp = 0; m_done = 0; m_hold = 1;
    end else if (m_hold) begin
      m_hold = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (zero) begin
        m_cur = 0; m_ramp = 0;
      end else if (m_ramp) begin
        if (stop) m_ramp = 0;
        else if (m_k > 0) m_k--;
        else begin
          if (m_cur < m_tgt) m_cur = (m_cur + m_stp > m_tgt) ? m_tgt : m_cur + m_stp;
          else               m_cur = (m_cur - m_stp < m_tgt) ? m_tgt : m_cur - m_stp;
          if (m_cur == m_tgt) begin m_ramp = 0; m_done = 1; end
          else m_k = m_dwl + 1;
        end
      end else if (start) begin
        m_tgt = target;
        m_stp = (step == 0) ? 1 : step;
        m_dwl = dwell;
        if (m_tgt == m_cur) m_done = 1;
        else begin m_ramp = 1; m_k = m_dwl + 1; end
      end else if (man_evt) begin
        if (man_dir) m_cur = (m_cur < 255) ? m_cur + 1 : 255;
        else         m_cur = (m_cur > 0) ? m_cur - 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_dac", dac, m_cur);
    chk("model_busy", busy, m_ramp);
    chk("model_done", done, m_done);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    start = 0; stop = 0; zero = 0; man_evt = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic ramp_to(input logic [7:0] t);
    start = 1; target = t; step = 8'd255; dwell = 0;
    cyc(); clr();
    wait_idle(50);
    cyc();
  endtask

  task automatic man(input logic d, input logic [7:0] exp, input string tag);
    man_evt = 1; man_dir = d; cyc(); clr();
    chk(tag, dac, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    cyc(); cyc();
    chk("reset_dac", dac, 0);
    chk("reset_busy", busy, 0);

    // Ramp up 10 -> 20, step 4, dwell 1
    ramp_to(8'd10);
    start = 1; target = 8'd20; step = 8'd4; dwell = 16'd1; cyc(); clr();
    cyc(); cyc(); chk("up_hold", dac, 10);
    cyc();                   chk("up_14", dac, 14);
    repeat (3) cyc();        chk("up_18", dac, 18);
    repeat (3) cyc();        chk("up_20", dac, 20);
    chk("up_done", done, 1);
    cyc(); chk("up_done_clr", done, 0); chk("up_busy", busy, 0);

    // Ramp down 200 -> 3, step 50, dwell 0
    ramp_to(8'd200);
    start = 1; target = 8'd3; step = 8'd50; dwell = 0; cyc(); clr();
    cyc(); cyc();     chk("dn_150", dac, 150);
    repeat (2) cyc(); chk("dn_100", dac, 100);
    repeat (2) cyc(); chk("dn_50", dac, 50);
    repeat (2) cyc(); chk("dn_3", dac, 3);
    chk("dn_done", done, 1);
    cyc();

    // Manual saturation
    ramp_to(8'd254);
    man(1, 8'd255, "man_up1"); man(1, 8'd255, "man_up2"); man(1, 8'd255, "man_up3");
    ramp_to(8'd1);
    man(0, 8'd0, "man_dn1"); man(0, 8'd0, "man_dn2"); man(0, 8'd0, "man_dn3");

    // Abort mid-dwell at 18
    ramp_to(8'd10);
    start = 1; target = 8'd40; step = 8'd8; dwell = 16'd3; cyc(); clr();
    begin
      int n = 0;
      while (dac != 8'd18 && n < 40) begin cyc(); n++; end
      chk("abort_reach18", dac, 18);
    end
    cyc();
    stop = 1; cyc(); clr();
    chk("abort_busy", busy, 0); chk("abort_dac", dac, 18);
    repeat (4) cyc(); chk("abort_hold", dac, 18);
    start = 1; target = 8'd20; step = 8'd1; dwell = 0; cyc(); clr();
    chk("abort_restart", busy, 1);
    wait_idle(20); chk("abort_final", dac, 20);
    cyc();

    // zero+stop during STEP wins over completion
    ramp_to(8'd0);
    start = 1; target = 8'd10; step = 8'd10; dwell = 16'd2; cyc(); clr();
    repeat (3) cyc();
    zero = 1; stop = 1; cyc(); clr();
    chk("prio_dac", dac, 0); chk("prio_busy", busy, 0); chk("prio_done", done, 0);
    start = 1; target = 8'd0; cyc(); clr();
    chk("eq_busy", busy, 0); chk("eq_done", done, 1);
    cyc(); chk("eq_done_clr", done, 0);

    // Async reset mid-ramp, between edges
    start = 1; target = 8'd200; step = 8'd5; dwell = 0; cyc(); clr();
    repeat (5) cyc();
    @(negedge clk); #2 rst = 1;
    #1 chk("arst_dac", dac, 0); chk("arst_busy", busy, 0);
    @(negedge clk); rst = 0;
    man_evt = 1; man_dir = 1;
    cyc(); chk("rel_edge1", dac, 0);
    cyc(); chk("rel_edge2", dac, 1);
    clr();
    zero = 1; cyc(); clr();
    start = 1; target = 8'd3; step = 8'd0; dwell = 0; cyc(); clr();
    cyc(); cyc();     chk("s0_1", dac, 1);
    repeat (2) cyc(); chk("s0_2", dac, 2);
    repeat (2) cyc(); chk("s0_3", dac, 3);
    chk("s0_done", done, 1);
    cyc();

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      zero    = ($urandom_range(0, 63) == 0);
      stop    = ($urandom_range(0, 31) == 0);
      start   = ($urandom_range(0, 7) == 0);
      man_evt = ($urandom_range(0, 3) == 0);
      man_dir = $urandom_range(0, 1);
      target  = $urandom_range(0, 255);
      step    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      dwell   = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk); #2 rst = 1;
        @(negedge clk); rst = 0;
      end
      cyc();
    end
    clr();
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
